// File: rtl/sobel_edge_if.sv
// Video stream bundle for the Sobel edge block: raw luminance stream in,
// delayed sync plus edge flag / magnitude / direction out.
interface sobel_edge_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W+2:0] thresh;
  logic              per_img_vsync;
  logic              per_img_href;
  logic              per_img_clken;
  logic [DATA_W-1:0] per_img_gray;
  logic              post_img_vsync;
  logic              post_img_href;
  logic              post_img_clken;
  logic              post_img_bit;
  logic [DATA_W-1:0] post_img_mag;
  logic [1:0]        post_img_dir;

  modport master (
    output thresh, per_img_vsync, per_img_href, per_img_clken, per_img_gray,
    input  post_img_vsync, post_img_href, post_img_clken, post_img_bit,
           post_img_mag, post_img_dir
  );

  modport slave (
    input  thresh, per_img_vsync, per_img_href, per_img_clken, per_img_gray,
    output post_img_vsync, post_img_href, post_img_clken, post_img_bit,
           post_img_mag, post_img_dir
  );
endinterface

// File: rtl/sobel_edge_param.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a window, then a
// free-running 4-stage pipeline yields edge flag, saturated magnitude, direction.
module sobel_edge_param #(
  parameter int DATA_W    = 8,
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int MAG_SHIFT = 0
) (
  input logic         clk,
  input logic         rst_n,
  sobel_edge_if.slave bus
);
  localparam int CW = $clog2(IMG_HDISP + 1);
  localparam int RW = $clog2(IMG_VDISP + 1);
  localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int PW = DATA_W + 2;
  localparam int SW = DATA_W + 3;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP);
  localparam logic [SW-1:0] MAG_MAX = {3'b000, {DATA_W{1'b1}}};

  function automatic logic [PW-1:0] tap3(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [DATA_W-1:0] c);
    return PW'(a) + PW'({b, 1'b0}) + PW'(c);
  endfunction

  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] a,
                                             input logic [PW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic              accept_s, href_fall_s, vsync_rise_s, in_line_s;
  logic [AW-1:0]     addr_s;
  logic [DATA_W-1:0] lb1_rd_s, lb2_rd_s;
  logic              href_d_r, vsync_d_r;
  logic [CW-1:0]     col_r;
  logic [RW-1:0]     row_r;
  logic [SW-1:0]     thresh_r;
  logic [DATA_W-1:0] lb1_r [IMG_HDISP];
  logic [DATA_W-1:0] lb2_r [IMG_HDISP];
  logic [DATA_W-1:0] p11_r, p12_r, p13_r, p21_r, p22_r, p23_r, p31_r, p32_r, p33_r;
  logic              v1_r, v2_r, v3_r;
  logic [PW-1:0]     right_r, left_r, bot_r, top_r;
  logic [PW-1:0]     agx_r, agy_r;
  logic              ngx_r, ngy_r;
  logic [2:0][2:0]   sync_d_r;
  logic [SW-1:0]     sum_s, shifted_s;
  logic [DATA_W-1:0] mag_s;
  logic [1:0]        dir_s;

  // Pixel accept, sync edge detection and line-buffer read at the column address
  always_comb begin
    accept_s     = bus.per_img_clken & bus.per_img_href;
    href_fall_s  = href_d_r & ~bus.per_img_href;
    vsync_rise_s = ~vsync_d_r & bus.per_img_vsync;
    addr_s       = col_r[AW-1:0];
    in_line_s    = (col_r < COL_MAX);
    if (in_line_s) begin
      lb1_rd_s = lb1_r[addr_s];
      lb2_rd_s = lb2_r[addr_s];
    end else begin
      lb1_rd_s = '0;
      lb2_rd_s = '0;
    end
  end

  // Column/row counters and per-frame threshold latch; frame start beats line end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_d_r  <= 1'b0;
      vsync_d_r <= 1'b0;
      col_r     <= '0;
      row_r     <= '0;
      thresh_r  <= '0;
    end else begin
      href_d_r  <= bus.per_img_href;
      vsync_d_r <= bus.per_img_vsync;
      if (href_fall_s) begin
        col_r <= '0;
      end else if (accept_s && in_line_s) begin
        col_r <= col_r + CW'(1);
      end
      if (vsync_rise_s) begin
        row_r    <= '0;
        thresh_r <= bus.thresh;
      end else if (href_fall_s && (row_r < ROW_MAX)) begin
        row_r <= row_r + RW'(1);
      end
    end
  end

  // Line buffers are deliberately not reset; border masking hides stale rows
  always_ff @(posedge clk) begin
    if (accept_s && in_line_s) begin
      lb1_r[addr_s] <= bus.per_img_gray;
      lb2_r[addr_s] <= lb1_rd_s;
    end
  end

  // Stage 1: 3x3 window shifts only on accepted pixels, border flag travels along
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {p11_r, p12_r, p13_r, p21_r, p22_r, p23_r, p31_r, p32_r, p33_r} <= '0;
      v1_r <= 1'b0;
    end else if (accept_s) begin
      p11_r <= p12_r;  p12_r <= p13_r;  p13_r <= lb2_rd_s;
      p21_r <= p22_r;  p22_r <= p23_r;  p23_r <= lb1_rd_s;
      p31_r <= p32_r;  p32_r <= p33_r;  p33_r <= bus.per_img_gray;
      v1_r  <= (row_r >= RW'(2)) && (col_r >= CW'(2)) && in_line_s;
    end
  end

  // Stages 2 and 3: weighted column/row sums, then |Gx|, |Gy| and their signs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {right_r, left_r, bot_r, top_r} <= '0;
      {agx_r, agy_r}                  <= '0;
      {ngx_r, ngy_r, v2_r, v3_r}      <= '0;
    end else begin
      right_r <= tap3(p13_r, p23_r, p33_r);
      left_r  <= tap3(p11_r, p21_r, p31_r);
      bot_r   <= tap3(p31_r, p32_r, p33_r);
      top_r   <= tap3(p11_r, p12_r, p13_r);
      v2_r    <= v1_r;
      agx_r   <= abs_diff(right_r, left_r);
      agy_r   <= abs_diff(bot_r, top_r);
      ngx_r   <= (right_r < left_r);
      ngy_r   <= (bot_r < top_r);
      v3_r    <= v2_r;
    end
  end

  // Stage 4 arithmetic: magnitude saturation and direction quantisation
  always_comb begin
    sum_s     = SW'(agx_r) + SW'(agy_r);
    shifted_s = sum_s >> MAG_SHIFT;
    if (shifted_s > MAG_MAX) begin
      mag_s = '1;
    end else begin
      mag_s = shifted_s[DATA_W-1:0];
    end
    if ({agy_r, 1'b0} <= {1'b0, agx_r}) begin
      dir_s = 2'd0;
    end else if ({agx_r, 1'b0} <= {1'b0, agy_r}) begin
      dir_s = 2'd2;
    end else if (ngx_r == ngy_r) begin
      dir_s = 2'd1;
    end else begin
      dir_s = 2'd3;
    end
  end

  // Stage 4 registers: sync delay line tail and masked edge results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d_r           <= '0;
      bus.post_img_vsync <= 1'b0;
      bus.post_img_href  <= 1'b0;
      bus.post_img_clken <= 1'b0;
      bus.post_img_bit   <= 1'b0;
      bus.post_img_mag   <= '0;
      bus.post_img_dir   <= 2'd0;
    end else begin
      sync_d_r[0]        <= {bus.per_img_vsync, bus.per_img_href, bus.per_img_clken};
      sync_d_r[1]        <= sync_d_r[0];
      sync_d_r[2]        <= sync_d_r[1];
      bus.post_img_vsync <= sync_d_r[2][2];
      bus.post_img_href  <= sync_d_r[2][1];
      bus.post_img_clken <= sync_d_r[2][0];
      if (v3_r) begin
        bus.post_img_bit <= (sum_s > thresh_r);
        bus.post_img_mag <= mag_s;
        bus.post_img_dir <= dir_s;
      end else begin
        bus.post_img_bit <= 1'b0;
        bus.post_img_mag <= '0;
        bus.post_img_dir <= 2'd0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_edge_param.sv
// Bench for sobel_edge_param: frame-level stimulus against an image-array
// Sobel model, a spot-value table, and hand sequences for latency/threshold/reset.
module tb_sobel_edge_param;
  localparam int DW = 8;
  localparam int HD = 8;
  localparam int VD = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sobel_edge_if #(.DATA_W(DW)) bus ();

  sobel_edge_param #(.DATA_W(DW), .IMG_HDISP(HD), .IMG_VDISP(VD), .MAG_SHIFT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic vs, hs, ck;
    bit   chk;
    int   r, c, b, m, d;
  } exp_t;

  typedef struct {
    int pat, r, c, b, m, d;
  } vec_t;

  int     n_cmp = 0;
  int     n_err = 0;
  int     img [VD][HD];
  int     cap_bit [VD][HD];
  int     cap_mag [VD][HD];
  int     cap_dir [VD][HD];
  int     thr_lat = 0;
  bit     data_chk = 1'b1;
  exp_t   pipe [$];
  vec_t   tbl [$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input int pat, input int r, input int c, input int b, input int m, input int d);
    vec_t v;
    v.pat = pat; v.r = r; v.c = c; v.b = b; v.m = m; v.d = d;
    tbl.push_back(v);
  endtask

  // Sobel reference straight from the image array and the frame's latched threshold
  function automatic void model(input int r, input int c, output int b, output int m, output int d);
    int gx, gy, ax, ay, s;
    b = 0; m = 0; d = 0;
    if (r < 2 || c < 2) return;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    s  = ax + ay;
    b  = (s > thr_lat) ? 1 : 0;
    m  = (s > 255) ? 255 : s;
    if (2*ay <= ax)                d = 0;
    else if (2*ax <= ay)           d = 2;
    else if ((gx < 0) == (gy < 0)) d = 1;
    else                           d = 3;
  endfunction

  task automatic chk_zero(input string tag);
    cmp({tag, "_vs"},  bus.post_img_vsync, 0);
    cmp({tag, "_hs"},  bus.post_img_href,  0);
    cmp({tag, "_ck"},  bus.post_img_clken, 0);
    cmp({tag, "_bit"}, bus.post_img_bit,   0);
    cmp({tag, "_mag"}, bus.post_img_mag,   0);
    cmp({tag, "_dir"}, bus.post_img_dir,   0);
  endtask

  // One clock: drive inputs, then check the record launched three ticks earlier
  task automatic tick(input logic vs, input logic hs, input logic ck, input logic [7:0] g,
                      input int r, input int c);
    exp_t e;
    int   b, m, d;
    bus.per_img_vsync = vs;
    bus.per_img_href  = hs;
    bus.per_img_clken = ck;
    bus.per_img_gray  = g;
    e.vs = vs; e.hs = hs; e.ck = ck; e.r = r; e.c = c;
    e.chk = data_chk && hs && ck && (r >= 0);
    b = 0; m = 0; d = 0;
    if (e.chk) model(r, c, b, m, d);
    e.b = b; e.m = m; e.d = d;
    pipe.push_back(e);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      chk_zero("in_reset");
      pipe.delete();
    end else if (pipe.size() == 4) begin
      e = pipe.pop_front();
      cmp("post_vsync", bus.post_img_vsync, e.vs);
      cmp("post_href",  bus.post_img_href,  e.hs);
      cmp("post_clken", bus.post_img_clken, e.ck);
      if (e.chk) begin
        cmp($sformatf("bit_r%0d_c%0d", e.r, e.c), bus.post_img_bit, e.b);
        cmp($sformatf("mag_r%0d_c%0d", e.r, e.c), bus.post_img_mag, e.m);
        cmp($sformatf("dir_r%0d_c%0d", e.r, e.c), bus.post_img_dir, e.d);
        cap_bit[e.r][e.c] = int'(bus.post_img_bit);
        cap_mag[e.r][e.c] = int'(bus.post_img_mag);
        cap_dir[e.r][e.c] = int'(bus.post_img_dir);
      end
    end
  endtask

  // Full frame with random clken gaps; optional mid-frame thresh change or reset pulse
  task automatic run_frame(input int pat, input int thr, input int thr_mid, input int rst_row);
    for (int r = 0; r < VD; r++) begin
      for (int c = 0; c < HD; c++) begin
        case (pat)
          0:       img[r][c] = 100;
          1:       img[r][c] = (c >= 4) ? 255 : 0;
          2:       img[r][c] = (r >= 3) ? 200 : 0;
          3:       img[r][c] = int'($urandom_range(0, 255));
          default: img[r][c] = int'($urandom_range(0, 15));
        endcase
        cap_bit[r][c] = -1; cap_mag[r][c] = -1; cap_dir[r][c] = -1;
      end
    end
    data_chk   = 1'b1;
    bus.thresh = 11'(thr);
    thr_lat    = thr;
    tick(1'b1, 1'b0, 1'b0, 8'd0, -1, -1);
    tick(1'b1, 1'b0, 1'b0, 8'd0, -1, -1);
    for (int r = 0; r < VD; r++) begin
      if (r == 2 && thr_mid >= 0) bus.thresh = 11'(thr_mid);
      for (int c = 0; c < HD; c++) begin
        if (r == rst_row && c == 3) begin
          rst_n = 1'b0;
          #1;
          chk_zero("rst_async");
          for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 1'b0, 8'd0, -1, -1);
          rst_n    = 1'b1;
          data_chk = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) tick(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), -1, -1);
        tick(1'b1, 1'b1, 1'b1, 8'(img[r][c]), r, c);
      end
      for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0, 8'd0, -1, -1);
    end
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, 1'b0, 8'd0, -1, -1);
  endtask

  task automatic check_table(input int pat);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].pat == pat) begin
        cmp($sformatf("tbl%0d_bit", i), cap_bit[tbl[i].r][tbl[i].c], tbl[i].b);
        cmp($sformatf("tbl%0d_mag", i), cap_mag[tbl[i].r][tbl[i].c], tbl[i].m);
        cmp($sformatf("tbl%0d_dir", i), cap_dir[tbl[i].r][tbl[i].c], tbl[i].d);
      end
    end
  endtask

  function automatic int edge_count();
    int n = 0;
    for (int r = 0; r < VD; r++)
      for (int c = 0; c < HD; c++)
        if (cap_bit[r][c] == 1) n++;
    return n;
  endfunction

  initial begin
    // flat / vertical step / horizontal step spot values
    add_vec(0, 2, 2, 0, 0, 0);   add_vec(0, 5, 7, 0, 0, 0);   add_vec(0, 3, 4, 0, 0, 0);
    add_vec(1, 2, 4, 1, 255, 0); add_vec(1, 5, 5, 1, 255, 0); add_vec(1, 3, 6, 0, 0, 0);
    add_vec(1, 3, 3, 0, 0, 0);   add_vec(1, 1, 4, 0, 0, 0);   add_vec(1, 4, 1, 0, 0, 0);
    add_vec(2, 3, 2, 1, 255, 2); add_vec(2, 4, 7, 1, 255, 2); add_vec(2, 5, 4, 0, 0, 0);
    add_vec(2, 2, 5, 0, 0, 0);   add_vec(2, 3, 1, 0, 0, 0);

    bus.thresh = '0; bus.per_img_vsync = 1'b0; bus.per_img_href = 1'b0;
    bus.per_img_clken = 1'b0; bus.per_img_gray = '0;
    #1 rst_n = 1'b0;
    #2 chk_zero("reset_state");
    tick(1'b0, 1'b0, 1'b0, 8'd0, -1, -1);
    tick(1'b0, 1'b0, 1'b0, 8'd0, -1, -1);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b0, 8'd0, -1, -1);

    run_frame(0, 10, -1, -1);
    cmp("flat_edges", edge_count(), 0);
    check_table(0);
    run_frame(1, 500, -1, -1);
    cmp("vstep_edges", edge_count(), 8);
    check_table(1);
    run_frame(2, 100, -1, -1);
    cmp("hstep_edges", edge_count(), 12);
    check_table(2);

    run_frame(1, 500, 2000, -1);
    cmp("thr_frame1_edges", edge_count(), 8);
    run_frame(1, 2000, -1, -1);
    cmp("thr_frame2_edges", edge_count(), 0);

    // lone pixel: strobe must emerge on exactly one cycle, four clocks later
    tick(1'b0, 1'b1, 1'b1, 8'd77, -1, -1);
    for (int t = 0; t < 6; t++) begin
      tick(1'b0, 1'b0, 1'b0, 8'd0, -1, -1);
      cmp($sformatf("single_clken_t%0d", t), bus.post_img_clken, (t == 2) ? 1 : 0);
    end

    run_frame(1, 500, -1, 3);
    run_frame(1, 500, -1, -1);
    cmp("after_reset_edges", edge_count(), 8);
    check_table(1);

    for (int f = 0; f < 3; f++) run_frame(3, int'($urandom_range(0, 1200)), -1, -1);
    for (int f = 0; f < 2; f++) run_frame(4, int'($urandom_range(0, 60)), -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sobel_edge_param.md
SOBEL_EDGE_PARAM -- requirements
Module: sobel_edge_param

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, pixel width; IMG_HDISP, 640, active pixels per line; IMG_VDISP, 480, active lines per frame; MAG_SHIFT, 0, right shift applied before magnitude saturation.
REQ-002 clk  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 thresh  in  DATA_W+3  binary threshold, unsigned; sampled per frame.
REQ-005 per_img_vsync  in  1  frame valid, active-high.
REQ-006 per_img_href  in  1  line valid, active-high.
REQ-007 per_img_clken  in  1  pixel strobe; pixel accepted when clken and href are both 1.
REQ-008 per_img_gray  in  DATA_W  input luminance.
REQ-009 post_img_vsync, post_img_href, post_img_clken  out  1 each  delayed sync/strobe.
REQ-010 post_img_bit  out  1  edge flag.
REQ-011 post_img_mag  out  DATA_W  saturated gradient magnitude.
REQ-012 post_img_dir  out  2  quantised gradient direction.

Function
REQ-013 Two internal line buffers, IMG_HDISP x DATA_W each, SHALL hold the previous two accepted lines; written and read at the column address on each accepted pixel.
REQ-014 Column counter SHALL increment per accepted pixel, saturate at IMG_HDISP, and clear on href falling edge; row counter SHALL increment on href falling edge, saturate at IMG_VDISP, and clear on vsync rising edge.
REQ-015 The 3x3 window SHALL shift only on accepted pixels; p33 = current pixel, p23/p13 = same column one/two lines earlier, columns 2/1 = one/two accepted pixels earlier.
REQ-016 Gx = (p13+2p23+p33)-(p11+2p21+p31), Gy = (p31+2p32+p33)-(p11+2p12+p13), signed DATA_W+3 bits, no overflow.
REQ-017 sum = |Gx|+|Gy|, unsigned DATA_W+3 bits; post_img_bit = (sum > thresh_latched).
REQ-018 post_img_mag = min(sum >> MAG_SHIFT, 2^DATA_W-1).
REQ-019 post_img_dir: 0 if 2|Gy| <= |Gx| (incl. Gx=Gy=0); else 2 if 2|Gx| <= |Gy|; else 1 if sign(Gx)=sign(Gy); else 3.
REQ-020 Pixels with row < 2, col < 2, or col >= IMG_HDISP SHALL output bit=0, mag=0, dir=0.
REQ-021 thresh SHALL be latched on the vsync rising edge only; mid-frame changes SHALL take effect from the next frame.
REQ-022 Pipeline SHALL be free-running, 4 stages: window, partial sums, Gx/Gy with abs, magnitude/threshold/direction; outputs registered.
REQ-023 post_img_vsync/href/clken SHALL equal the corresponding inputs delayed exactly 4 clocks; data for an input accepted at edge k SHALL be present after edge k+4 with post_img_clken=1.
REQ-024 Data outputs are don't-care when post_img_clken=0 but SHALL remain deterministic (no X after reset).
REQ-025 Simultaneous href falling edge and vsync rising edge: row counter SHALL clear (clear wins).

Reset
REQ-026 rst_n low SHALL immediately clear all outputs, delay lines, counters, window registers and thresh_latched to 0.
REQ-027 Line buffer contents SHALL NOT be reset; border masking (REQ-020) SHALL hide stale data.
REQ-028 Reset released mid-frame: block SHALL output masked/arbitrary-but-defined data until the next vsync rising edge, then process normally.

Verification (DATA_W=8, IMG_HDISP=8, IMG_VDISP=6, MAG_SHIFT=0)
REQ-029 Flat frame, all pixels 100, thresh=10 -> every post pixel bit=0, mag=0, dir=0.
REQ-030 Vertical step, cols 0-3=0, cols 4-7=255, thresh=500 -> rows 2-5 cols 4,5: sum 1020, bit=1, mag=255, dir=0; all others bit=0.
REQ-031 Horizontal step, rows 0-2=0, rows 3-5=200, thresh=100 -> rows 3,4 cols 2-7: sum 800, bit=1, mag=255, dir=2; row 5 bit=0.
REQ-032 Frame 1 thresh=500, changed to 2000 mid-frame 1, vertical-step image repeated -> frame 1 bits per REQ-030; frame 2 all bits 0.
REQ-033 Single accepted pixel at edge k -> post_img_clken high for exactly edge k+4; vsync/href edges shifted exactly 4 clocks.
REQ-034 rst_n low 3 cycles during row 3 -> all outputs 0 within the reset window; next frame reproduces REQ-030 results exactly.
